grasshopper_round_ctrl: RTL

Sequencer for the GOST R 34.12-2015 "Grasshopper" round datapath. It accepts one 128-bit plaintext block over a valid/ready handshake and drives the external round `stage` unit through round numbers 1..10. Each round's result is looped back as the next round's input, and the final block is presented on a valid/ready output. The block sits between the host/bus-facing wrapper and the round stage (key XOR, linear and non-linear pipeline), and owns the round counter, stage handshaking and a watchdog.

---
 rtl/grasshopper_round_ctrl_pkg.sv | 7 +
 rtl/grasshopper_round_ctrl_if.sv | 19 +
 rtl/grasshopper_round_ctrl_watchdog.sv | 14 +
 rtl/grasshopper_round_ctrl.sv | 57 +++++
 4 files changed

// File: rtl/grasshopper_round_ctrl_pkg.sv
// grasshopper_pkg: shared types and sizes for the Grasshopper round sequencer
package grasshopper_pkg;
   localparam int GH_BLOCK_W = 128;
   localparam int GH_ROUNDS = 10;
   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} gh_state_t;
   typedef logic [3:0] gh_round_t;
endpackage

// File: rtl/grasshopper_round_ctrl_if.sv
// grasshopper_round_ctrl_if: host input, result output and round-stage handshakes
interface grasshopper_round_ctrl_if import grasshopper_pkg::*; #(parameter int BLOCK_W = GH_BLOCK_W);
   logic in_valid_i, in_ready_o;
   logic [BLOCK_W-1:0] in_data_i;
   logic out_valid_o, out_ready_i;
   logic [BLOCK_W-1:0] out_data_o;
   logic stage_valid_o, stage_valid_i;
   gh_round_t stage_num_o;
   logic [BLOCK_W-1:0] stage_data_o, stage_data_i;
   logic busy_o, err_o;
   modport slave (
      input in_valid_i, in_data_i, out_ready_i, stage_valid_i, stage_data_i,
      output in_ready_o, out_valid_o, out_data_o, stage_valid_o, stage_num_o, stage_data_o, busy_o, err_o
   );
   modport master (
      output in_valid_i, in_data_i, out_ready_i, stage_valid_i, stage_data_i,
      input in_ready_o, out_valid_o, out_data_o, stage_valid_o, stage_num_o, stage_data_o, busy_o, err_o
   );
endinterface

// File: rtl/grasshopper_round_ctrl_watchdog.sv
// gh_watchdog: saturating cycle counter; expired flags the cycle whose increment reaches LIMIT
module gh_watchdog #(parameter int LIMIT = 255) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [7:0] count;
   always_ff @(posedge clk)
      if (rst || clear) count <= '0;
      else if (enable && count != 8'(LIMIT)) count <= count + 8'd1;
   assign expired = enable && (count >= 8'(LIMIT - 1));
endmodule

// File: rtl/grasshopper_round_ctrl.sv
// grasshopper_round_ctrl: drives the external round stage through rounds 1..ROUNDS with a watchdog
module grasshopper_round_ctrl import grasshopper_pkg::*; #(
   parameter int BLOCK_W = GH_BLOCK_W,
   parameter int ROUNDS = GH_ROUNDS,
   parameter int TIMEOUT = 255
) (
   input logic clk,
   input logic rst,
   grasshopper_round_ctrl_if.slave bus
);
   gh_state_t state;
   gh_round_t round;
   logic [BLOCK_W-1:0] blk;
   logic err, wd_clear, wd_en, wd_exp;
   // the issue cycle counts as the first waited cycle, so the counter restarts on entry to ISSUE
   assign wd_en = state == ST_ISSUE || state == ST_WAIT;
   assign wd_clear = (state == ST_WAIT) ? bus.stage_valid_i : !wd_en;
   gh_watchdog #(.LIMIT(TIMEOUT)) u_wd (
      .clk(clk), .rst(rst), .clear(wd_clear), .enable(wd_en), .expired(wd_exp)
   );
   always_ff @(posedge clk)
      if (rst) begin
         state <= ST_IDLE;
         round <= '0;
         blk <= '0;
         err <= 1'b0;
      end else case (state)
         ST_IDLE: if (bus.in_valid_i) begin
            blk <= bus.in_data_i;
            round <= 4'd1;
            err <= 1'b0;
            state <= ST_ISSUE;
         end
         ST_ISSUE: state <= ST_WAIT;
         ST_WAIT: if (bus.stage_valid_i) begin
            blk <= bus.stage_data_i;
            if (round == gh_round_t'(ROUNDS)) state <= ST_DONE;
            else begin
               round <= round + 4'd1;
               state <= ST_ISSUE;
            end
         end else if (wd_exp) begin
            err <= 1'b1;
            state <= ST_IDLE;
         end
         ST_DONE: if (bus.out_ready_i) state <= ST_IDLE;
         default: state <= ST_IDLE;
      endcase
   assign bus.in_ready_o = state == ST_IDLE;
   assign bus.out_valid_o = state == ST_DONE;
   assign bus.out_data_o = blk;
   assign bus.stage_valid_o = state == ST_ISSUE;
   assign bus.stage_num_o = round;
   assign bus.stage_data_o = blk;
   assign bus.busy_o = state != ST_IDLE;
   assign bus.err_o = err;
endmodule
